mvm_axis_loader: RTL
====================

Name: mvm_axis_loader

Overview:
- Upstream feeder for the MVM tile.
- Accepts a host command (op, base address, beat count, destination) plus a stream of DATAW-wide data words.
- Emits AXI-Stream beats on the MVM rx port, with tuser encoded as the MVM expects: [8:0] address, [10:9] op, [11] RF write flag.
- Replaces hand-driven tuser sequences with a burst engine that auto-increments addresses and respects tready backpressure.

Parameters:
- DATAW, 512, data word / tdata width
- BYTEW, 8, tstrb/tkeep width
- IDW, 32, tid width
- DESTW, 12, tdest width
- USERW, 75, tuser width
- RFADDRW, 9, address field width in tuser[8:0]
- MAXLEN, 64, maximum beats per command
- LENW, $clog2(MAXLEN+1), cmd_len width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_op  in  2  11=RF write, 10=input vector, 01=reduction vector, 00=instruction
- cmd_addr  in  RFADDRW  base address
- cmd_len  in  LENW  number of beats, 1..MAXLEN
- cmd_dest  in  DESTW  tdest for all beats of the command
- data_valid  in  1  data word valid
- data_ready  out  1  data word consumed when data_valid&data_ready
- data_in  in  DATAW  payload word
- axis_tx_tvalid/tdata/tstrb/tkeep/tid/tdest/tuser/tlast  out  1/DATAW/BYTEW/BYTEW/IDW/DESTW/USERW/1  AXIS master to MVM rx
- axis_tx_tready  in  1  MVM rx tready
- busy  out  1  burst in progress or output beat pending
- cmd_err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous, active-low.
- Reset values:
  - tvalid, tdata, tuser, tdest, tid, tlast, busy, cmd_err, data_ready = 0.
  - cmd_ready = 1 after reset release.
  - FSM goes to IDLE.
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On handshake with cmd_len in 1..MAXLEN: latch op, addr, len, dest; clear beat counter; go to BURST.
  - cmd_len=0 or >MAXLEN: pulse cmd_err next cycle, drop the command, stay in IDLE.
- BURST:
  - cmd_ready=0.
  - data_ready = !axis_tx_tvalid || axis_tx_tready (single output register, full throughput).
  - On data handshake, the output register loads on the next edge:
    - tdata = data_in
    - tuser[8:0] = cur_addr
    - tuser[10:9] = op
    - tuser[11] = (op==11)
    - tuser[USERW-1:12] = 0
    - tstrb = tkeep = all ones; tid = 0; tdest = latched dest
  - After the handshake, the beat counter increments.
  - cur_addr increments per beat for op 11 and 00; it stays fixed for op 10 and 01.
  - Address increment wraps modulo 2^RFADDRW silently.
  - After the final beat is loaded, go to DRAIN.
- DRAIN:
  - data_ready=0.
  - When the last beat completes its tvalid&tready handshake, go to IDLE.
  - cmd_ready rises the cycle after the last beat handshake.
- Latency: data_in handshake to tvalid = 1 cycle.
- Output hold: tvalid stays asserted and payload stays stable until tready; no bubbles while data_valid and tready are both held high.
- Simultaneous tready-handshake and new data load in the same cycle: the register is replaced by the new beat with no gap.
- busy = (state!=IDLE).
- Reset mid-burst: the burst is abandoned, the output register is cleared, and remaining beats are not emitted.

Optional Feature:
- Macro: MVM_LOADER_PKT_LAST_EN.
- Defined: tlast=1 only on the final beat of each command; a burst forms one packet.
- Undefined (default): tlast=1 on every beat; each beat is a standalone single-beat packet, matching current MVM rx expectations.

Decomposition:
- Shared package mvm_pkg holds:
  - op encoding constants: OP_RF_WR=2'b11, OP_IVEC=2'b10, OP_RVEC=2'b01, OP_INST=2'b00
  - tuser field offsets: ADDR_LSB=0, OP_LSB=9, RFWR_BIT=11
  - FSM state typedef
- One natural sub-module: mvm_axis_out_reg, the single-entry AXIS output register with ready generation.

Test Plan:
- Single RF write: op=11, addr=9'h1, len=1, data=all 8'h01, tready=1 -> one beat; tuser[8:0]=1, [10:9]=11, [11]=1; tlast=1; tvalid one cycle after the data handshake.
- Input-vector burst: op=10, addr=5, len=4, data 8'h10..8'h13 -> four beats, all with tuser[8:0]=5, [11]=0, in order, back-to-back.
- Instruction burst with wrap: op=00, addr=9'h1FE, len=4 -> beat addresses 1FE, 1FF, 000, 001.
- Backpressure: op=11, len=3, tready toggled 1,0,0,1,0,1 -> payload stable while stalled, no loss or duplication, cmd_ready returns only after the third handshake.
- Illegal command: cmd_len=0 -> cmd_err pulses one cycle, no tvalid, FSM stays IDLE; a following valid command then executes.
- Reset mid-burst: rst low during beat 2 of len=8 -> tvalid=0 and cmd_ready=1 after release; no further beats emitted.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM AXIS loader: op encodings, tuser field offsets and FSM states.
`timescale 1ns/1ps
package mvm_pkg;

  localparam logic [1:0] OP_RF_WR = 2'b11;
  localparam logic [1:0] OP_IVEC  = 2'b10;
  localparam logic [1:0] OP_RVEC  = 2'b01;
  localparam logic [1:0] OP_INST  = 2'b00;

  localparam int ADDR_LSB = 0;
  localparam int OP_LSB   = 9;
  localparam int RFWR_BIT = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } loader_state_e;

  // RF writes and instructions fill consecutive slots; vectors target one fixed slot.
  function automatic logic addr_advances(input logic [1:0] op);
    logic adv;
    adv = 1'b0;
    case (op)
      OP_RF_WR, OP_INST: adv = 1'b1;
      OP_IVEC, OP_RVEC:  adv = 1'b0;
      default:           adv = 1'b0;
    endcase
    return adv;
  endfunction

endpackage

// File: rtl/mvm_axis_out_reg.sv
// Single-entry AXI-Stream output register; accepts a new beat whenever empty or draining.
`timescale 1ns/1ps
module mvm_axis_out_reg #(
  parameter int DATAW = 512,
  parameter int USERW = 75,
  parameter int DESTW = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DATAW-1:0] load_data,
  input  logic [USERW-1:0] load_user,
  input  logic [DESTW-1:0] load_dest,
  input  logic             load_last,
  output logic             can_load,
  output logic             tvalid,
  output logic [DATAW-1:0] tdata,
  output logic [USERW-1:0] tuser,
  output logic [DESTW-1:0] tdest,
  output logic             tlast,
  input  logic             tready
);

  assign can_load = !tvalid || tready;

  // A load in the same cycle as a completing handshake replaces the beat without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tuser  <= '0;
      tdest  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= load_data;
      tuser  <= load_user;
      tdest  <= load_dest;
      tlast  <= load_last;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/mvm_axis_loader.sv
// Burst engine turning host commands plus a data stream into MVM rx AXIS beats.
// Optional MVM_LOADER_PKT_LAST_EN: tlast only on the final beat of a command.
`timescale 1ns/1ps
module mvm_axis_loader
  import mvm_pkg::*;
#(
  parameter int DATAW   = 512,
  parameter int BYTEW   = 8,
  parameter int IDW     = 32,
  parameter int DESTW   = 12,
  parameter int USERW   = 75,
  parameter int RFADDRW = 9,
  parameter int MAXLEN  = 64,
  parameter int LENW    = $clog2(MAXLEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [RFADDRW-1:0] cmd_addr,
  input  logic [LENW-1:0]    cmd_len,
  input  logic [DESTW-1:0]   cmd_dest,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [DATAW-1:0]   data_in,
  output logic               axis_tx_tvalid,
  output logic [DATAW-1:0]   axis_tx_tdata,
  output logic [BYTEW-1:0]   axis_tx_tstrb,
  output logic [BYTEW-1:0]   axis_tx_tkeep,
  output logic [IDW-1:0]     axis_tx_tid,
  output logic [DESTW-1:0]   axis_tx_tdest,
  output logic [USERW-1:0]   axis_tx_tuser,
  output logic               axis_tx_tlast,
  input  logic               axis_tx_tready,
  output logic               busy,
  output logic               cmd_err
);

  loader_state_e      state, state_next;
  logic [1:0]         op_q;
  logic [RFADDRW-1:0] cur_addr;
  logic [LENW-1:0]    len_q;
  logic [LENW-1:0]    beat_cnt;
  logic [DESTW-1:0]   dest_q;
  logic               cmd_fire, cmd_legal, data_fire, can_load, final_beat, beat_last;
  logic [USERW-1:0]   beat_user;

  assign cmd_ready  = (state == IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign cmd_legal  = (cmd_len != '0) && (cmd_len <= LENW'(MAXLEN));
  assign data_ready = (state == BURST) && can_load;
  assign data_fire  = data_valid && data_ready;
  assign final_beat = ((beat_cnt + LENW'(1)) == len_q);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_fire && cmd_legal) state_next = BURST;
      BURST:   if (data_fire && final_beat) state_next = DRAIN;
      DRAIN:   if (axis_tx_tvalid && axis_tx_tready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command context and per-beat counters; illegal lengths are dropped with a one-cycle error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      cur_addr <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      dest_q   <= '0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= cmd_fire && !cmd_legal;
      if (cmd_fire && cmd_legal) begin
        op_q     <= cmd_op;
        cur_addr <= cmd_addr;
        len_q    <= cmd_len;
        dest_q   <= cmd_dest;
        beat_cnt <= '0;
      end else if (data_fire) begin
        beat_cnt <= beat_cnt + LENW'(1);
        if (addr_advances(op_q)) cur_addr <= cur_addr + RFADDRW'(1);
      end
    end
  end

  always_comb begin
    beat_user = '0;
    beat_user[ADDR_LSB +: RFADDRW] = cur_addr;
    beat_user[OP_LSB +: 2]         = op_q;
    beat_user[RFWR_BIT]            = (op_q == OP_RF_WR);
  end

`ifdef MVM_LOADER_PKT_LAST_EN
  assign beat_last = final_beat;
`else
  assign beat_last = 1'b1;
`endif

  assign axis_tx_tstrb = '1;
  assign axis_tx_tkeep = '1;
  assign axis_tx_tid   = '0;

  mvm_axis_out_reg #(
    .DATAW(DATAW),
    .USERW(USERW),
    .DESTW(DESTW)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (data_fire),
    .load_data(data_in),
    .load_user(beat_user),
    .load_dest(dest_q),
    .load_last(beat_last),
    .can_load (can_load),
    .tvalid   (axis_tx_tvalid),
    .tdata    (axis_tx_tdata),
    .tuser    (axis_tx_tuser),
    .tdest    (axis_tx_tdest),
    .tlast    (axis_tx_tlast),
    .tready   (axis_tx_tready)
  );

endmodule
